// File: rtl/pc_update_unit_pkg.sv
// Shared definitions for the program-counter stage of the multicycle MIPS datapath:
// next-PC select encodings, default widths and reset vector, alignment helper.
package pc_update_unit_pkg;

  localparam int unsigned DEFAULT_WORD_LENGTH       = 32;
  localparam int unsigned DEFAULT_JUMP_INDEX_LENGTH = 26;
  localparam logic [31:0] DEFAULT_RESET_VECTOR      = 32'h0040_0000;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_HOLD   = 2'b11
  } pc_src_e;

  // Instruction fetches must be word aligned; only the two low bits matter.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_update_unit_register.sv
// Enable-gated register with asynchronous active-high reset to a parameterised value.
// Used for the PC, the latched branch target and the captured faulting address.
module pc_register #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always_ff evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_update_unit.sv
// PC stage: holds the architectural PC and branch target, selects and commits the
// next PC under control strobes, and traps misaligned next-PC values.
module pc_update_unit #(
  parameter int unsigned WORD_LENGTH       = pc_update_unit_pkg::DEFAULT_WORD_LENGTH,
  parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = pc_update_unit_pkg::DEFAULT_RESET_VECTOR,
  parameter int unsigned JUMP_INDEX_LENGTH = pc_update_unit_pkg::DEFAULT_JUMP_INDEX_LENGTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PCWrite,
  input  logic                         PCWriteCond,
  input  logic                         BranchNotEqual,
  input  logic                         Zero,
  input  logic [1:0]                   PCSource,
  input  logic                         TargetWrite,
  input  logic [WORD_LENGTH-1:0]       ALUResult,
  input  logic [WORD_LENGTH-1:0]       BranchTarget,
  input  logic [JUMP_INDEX_LENGTH-1:0] JumpIndex,
  input  logic                         ErrAck,
  output logic [WORD_LENGTH-1:0]       PC,
  output logic [WORD_LENGTH-1:0]       TargetReg,
  output logic                         AddrErr,
  output logic [WORD_LENGTH-1:0]       BadVAddr,
  output logic                         PCCommit
);

  import pc_update_unit_pkg::*;

  localparam int unsigned REGION_BITS = WORD_LENGTH - JUMP_INDEX_LENGTH - 2;

  logic [WORD_LENGTH-1:0] jump_addr;
  logic [WORD_LENGTH-1:0] next_pc;
  logic                   taken;
  logic                   write_en;
  logic                   misaligned;
  logic                   fault;
  logic                   pc_en;
  logic                   bad_en;

  // The jump keeps the current PC's region bits, not those of PC+4.
  assign jump_addr = {PC[WORD_LENGTH-1 -: REGION_BITS], JumpIndex, 2'b00};

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_pc = PC;
    case (pc_src_e'(PCSource))
      PC_SRC_ALU:    next_pc = ALUResult;
      PC_SRC_BRANCH: next_pc = TargetReg;
      PC_SRC_JUMP:   next_pc = jump_addr;
      PC_SRC_HOLD:   next_pc = PC;
      default:       next_pc = PC;
    endcase
  end

  assign taken      = PCWriteCond & (Zero ^ BranchNotEqual);
  assign write_en   = (PCWrite | taken) & (PCSource != PC_SRC_HOLD);
  assign misaligned = is_misaligned(next_pc[1:0]);
  assign fault      = write_en & misaligned;
  assign pc_en      = write_en & ~misaligned;
  // Only the first fault is recorded until the control unit acknowledges it.
  assign bad_en     = fault & ~AddrErr;

  pc_register #(
    .WIDTH       (WORD_LENGTH),
    .RESET_VALUE (RESET_VECTOR)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (next_pc),
    .q     (PC)
  );

  // Branch mux reads the pre-edge TargetReg, so a same-edge reload is seen next time.
  pc_register #(
    .WIDTH       (WORD_LENGTH),
    .RESET_VALUE ('0)
  ) u_target (
    .clk   (clk),
    .reset (reset),
    .en    (TargetWrite),
    .d     (BranchTarget),
    .q     (TargetReg)
  );

  pc_register #(
    .WIDTH       (WORD_LENGTH),
    .RESET_VALUE ('0)
  ) u_bad_vaddr (
    .clk   (clk),
    .reset (reset),
    .en    (bad_en),
    .d     (next_pc),
    .q     (BadVAddr)
  );

  // A fault on the same edge as an acknowledge keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AddrErr  <= 1'b0;
      PCCommit <= 1'b0;
    end else begin
      PCCommit <= pc_en;
      if (fault) begin
        AddrErr <= 1'b1;
      end else if (ErrAck) begin
        AddrErr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: the driver queues hand-computed post-edge
// state for each vector and a monitor compares it one step after every rising edge.
module tb_pc_update_unit;

  localparam logic [31:0] RST_VEC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, BranchNotEqual, Zero, TargetWrite, ErrAck;
  logic [1:0]  PCSource;
  logic [31:0] ALUResult, BranchTarget;
  logic [25:0] JumpIndex;
  logic [31:0] PC, TargetReg, BadVAddr;
  logic        AddrErr, PCCommit;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        err;
    logic [31:0] bad;
    logic        commit;
  } exp_t;

  exp_t exp_q[$];

  pc_update_unit dut (
    .clk            (clk),
    .reset          (reset),
    .PCWrite        (PCWrite),
    .PCWriteCond    (PCWriteCond),
    .BranchNotEqual (BranchNotEqual),
    .Zero           (Zero),
    .PCSource       (PCSource),
    .TargetWrite    (TargetWrite),
    .ALUResult      (ALUResult),
    .BranchTarget   (BranchTarget),
    .JumpIndex      (JumpIndex),
    .ErrAck         (ErrAck),
    .PC             (PC),
    .TargetReg      (TargetReg),
    .AddrErr        (AddrErr),
    .BadVAddr       (BadVAddr),
    .PCCommit       (PCCommit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic err, input logic [31:0] bad, input logic commit);
    check({name, ".PC"},        PC,               pc);
    check({name, ".TargetReg"}, TargetReg,        tgt);
    check({name, ".AddrErr"},   {31'd0, AddrErr}, {31'd0, err});
    check({name, ".BadVAddr"},  BadVAddr,         bad);
    check({name, ".PCCommit"},  {31'd0, PCCommit}, {31'd0, commit});
  endtask

  // Monitor: outputs settle just after the edge that consumed the queued vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all(e.name, e.pc, e.tgt, e.err, e.bad, e.commit);
      end
    end
  end

  task automatic clear_inputs();
    PCWrite = 0; PCWriteCond = 0; BranchNotEqual = 0; Zero = 0; PCSource = 2'b00;
    TargetWrite = 0; ALUResult = '0; BranchTarget = '0; JumpIndex = '0; ErrAck = 0;
  endtask

  // Drive one vector on the falling edge and queue the state expected after the next rise.
  task automatic step(input string name,
                      input logic pcw, input logic pcc, input logic bne, input logic zero,
                      input logic [1:0] src, input logic tw, input logic [31:0] alu,
                      input logic [31:0] bt, input logic [25:0] ji, input logic ack,
                      input logic [31:0] e_pc, input logic [31:0] e_tgt, input logic e_err,
                      input logic [31:0] e_bad, input logic e_commit);
    exp_t e;
    @(negedge clk);
    PCWrite = pcw; PCWriteCond = pcc; BranchNotEqual = bne; Zero = zero; PCSource = src;
    TargetWrite = tw; ALUResult = alu; BranchTarget = bt; JumpIndex = ji; ErrAck = ack;
    e.name = name; e.pc = e_pc; e.tgt = e_tgt; e.err = e_err; e.bad = e_bad; e.commit = e_commit;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #1;
    check_all("reset", RST_VEC, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    //   name         pcw pcc bne z  src    tw alu            bt             ji          ack  pc            tgt           err bad           com
    step("alu_inc",    1, 0, 0, 0, 2'b00, 0, 32'h0040_0004, 32'h0,        26'h0,       0,  32'h0040_0004, 32'h0,        0, 32'h0,        1);
    #1 check("pre_edge.PC", PC, RST_VEC);
    step("idle",       0, 0, 0, 0, 2'b00, 0, 32'h0,        32'h0,        26'h0,       0,  32'h0040_0004, 32'h0,        0, 32'h0,        0);
    step("tgt_write",  0, 0, 0, 0, 2'b00, 1, 32'h0,        32'h0040_0020, 26'h0,      0,  32'h0040_0004, 32'h0040_0020, 0, 32'h0,       0);
    step("beq_taken",  0, 1, 0, 1, 2'b01, 0, 32'h0,        32'h0,        26'h0,       0,  32'h0040_0020, 32'h0040_0020, 0, 32'h0,       1);
    step("reload",     1, 0, 0, 0, 2'b00, 0, 32'h0040_0008, 32'h0,        26'h0,      0,  32'h0040_0008, 32'h0040_0020, 0, 32'h0,       1);
    step("beq_not",    0, 1, 0, 0, 2'b01, 0, 32'h0,        32'h0,        26'h0,       0,  32'h0040_0008, 32'h0040_0020, 0, 32'h0,       0);
    step("bne_taken",  0, 1, 1, 0, 2'b01, 0, 32'h0,        32'h0,        26'h0,       0,  32'h0040_0020, 32'h0040_0020, 0, 32'h0,       1);
    step("reload2",    1, 0, 0, 0, 2'b00, 0, 32'h0040_0008, 32'h0,        26'h0,      0,  32'h0040_0008, 32'h0040_0020, 0, 32'h0,       1);
    step("bne_not",    0, 1, 1, 1, 2'b01, 0, 32'h0,        32'h0,        26'h0,       0,  32'h0040_0008, 32'h0040_0020, 0, 32'h0,       0);
    step("jump",       1, 0, 0, 0, 2'b10, 0, 32'h0,        32'h0,        26'h0100010, 0,  32'h0040_0040, 32'h0040_0020, 0, 32'h0,       1);
    step("src_hold",   1, 0, 0, 0, 2'b11, 0, 32'h0040_0100, 32'h0,        26'h0,      0,  32'h0040_0040, 32'h0040_0020, 0, 32'h0,       0);
    step("both_strb",  1, 1, 0, 0, 2'b00, 0, 32'h0040_0044, 32'h0,        26'h0,      0,  32'h0040_0044, 32'h0040_0020, 0, 32'h0,       1);
    step("fault1",     1, 0, 0, 0, 2'b00, 0, 32'h0040_0006, 32'h0,        26'h0,      0,  32'h0040_0044, 32'h0040_0020, 1, 32'h0040_0006, 0);
    step("fault2",     1, 0, 0, 0, 2'b00, 0, 32'h0040_0003, 32'h0,        26'h0,      0,  32'h0040_0044, 32'h0040_0020, 1, 32'h0040_0006, 0);
    step("write_err",  1, 0, 0, 0, 2'b00, 0, 32'h0040_0080, 32'h0,        26'h0,      0,  32'h0040_0080, 32'h0040_0020, 1, 32'h0040_0006, 1);
    step("ack",        0, 0, 0, 0, 2'b00, 0, 32'h0,        32'h0,        26'h0,       1,  32'h0040_0080, 32'h0040_0020, 0, 32'h0040_0006, 0);
    step("ack_fault",  1, 0, 0, 0, 2'b00, 0, 32'h0040_0002, 32'h0,        26'h0,      1,  32'h0040_0080, 32'h0040_0020, 1, 32'h0040_0002, 0);
    step("ack2",       0, 0, 0, 0, 2'b00, 0, 32'h0,        32'h0,        26'h0,       1,  32'h0040_0080, 32'h0040_0020, 0, 32'h0040_0002, 0);
    step("rd_b4_wr",   1, 0, 0, 0, 2'b01, 1, 32'h0,        32'h0040_0100, 26'h0,      0,  32'h0040_0020, 32'h0040_0100, 0, 32'h0040_0002, 1);
    step("br_fault",   0, 1, 0, 1, 2'b01, 1, 32'h0,        32'h0040_0102, 26'h0,      0,  32'h0040_0100, 32'h0040_0102, 0, 32'h0040_0002, 1);
    step("br_fault2",  0, 1, 0, 1, 2'b01, 0, 32'h0,        32'h0,        26'h0,       0,  32'h0040_0100, 32'h0040_0102, 1, 32'h0040_0102, 0);
    step("to_top",     1, 0, 0, 0, 2'b00, 0, 32'hFFFF_FFFC, 32'h0,        26'h0,      1,  32'hFFFF_FFFC, 32'h0040_0102, 0, 32'h0040_0102, 1);
    step("jump_hi",    1, 0, 0, 0, 2'b10, 0, 32'h0,        32'h0,        26'h0000001, 0,  32'hF000_0004, 32'h0040_0102, 0, 32'h0040_0102, 1);
    step("to_top2",    1, 0, 0, 0, 2'b00, 0, 32'hFFFF_FFFC, 32'h0,        26'h0,      0,  32'hFFFF_FFFC, 32'h0040_0102, 0, 32'h0040_0102, 1);
    step("wrap",       1, 0, 0, 0, 2'b00, 0, 32'h0000_0000, 32'h0,        26'h0,      0,  32'h0000_0000, 32'h0040_0102, 0, 32'h0040_0102, 1);
    step("fault_pre",  1, 0, 0, 0, 2'b00, 0, 32'h0000_0001, 32'h0,        26'h0,      0,  32'h0000_0000, 32'h0040_0102, 1, 32'h0000_0001, 0);
    @(negedge clk);
    clear_inputs();
    drain();

    // Asynchronous reset mid-cycle while a write is pending.
    @(negedge clk);
    PCWrite = 1; PCSource = 2'b00; ALUResult = 32'h0040_0010; TargetWrite = 1; BranchTarget = 32'h1234_5678;
    #2 reset = 1'b1;
    #1 check_all("async_rst", RST_VEC, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1 check_all("rst_held", RST_VEC, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    step("post_rst",   1, 0, 0, 0, 2'b00, 0, 32'h0040_0004, 32'h0,        26'h0,      0,  32'h0040_0004, 32'h0,        0, 32'h0,        1);
    @(negedge clk);
    clear_inputs();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
